// File: rtl/clk_div_bank_if.sv
// clk_div_bank_if
//   Groups the control and output signals of clk_div_bank.
//   master : drives en / load / load_ch / load_div and observes load_ack / div_out / tick.
//   slave  : the divider bank itself.
//   Signals:
//     en       [CHANNELS]  per-channel count enable
//     load                 single-cycle ratio write request
//     load_ch  [LCH_W]     target channel of load
//     load_div [CNT_W]     requested ratio (0 is treated as 1)
//     load_ack             one-cycle confirmation of an accepted load
//     div_out  [CHANNELS]  divided square waves
//     tick     [CHANNELS]  one-cycle strobe per period
interface clk_div_bank_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32,
  parameter int LCH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic [CHANNELS-1:0] en;
  logic                load;
  logic [LCH_W-1:0]    load_ch;
  logic [CNT_W-1:0]    load_div;
  logic                load_ack;
  logic [CHANNELS-1:0] div_out;
  logic [CHANNELS-1:0] tick;

  modport master (
    output en, load, load_ch, load_div,
    input  load_ack, div_out, tick
  );

  modport slave (
    input  en, load, load_ch, load_div,
    output load_ack, div_out, tick
  );
endinterface

// File: rtl/clk_div_bank.sv
// clk_div_bank
//   Bank of CHANNELS independent, runtime-programmable clock dividers. Each
//   channel produces a registered square wave (div_out) and a one-cycle strobe
//   per period (tick). New ratios are staged as pending and only swapped in at
//   a period boundary (or while the channel is disabled) so no runt period is
//   ever emitted.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset; clears all outputs immediately
//     bus    clk_div_bank_if.slave (en, load, load_ch, load_div, load_ack,
//            div_out, tick)
module clk_div_bank #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 50
) (
  input logic           clk,
  input logic           rst_n,
  clk_div_bank_if.slave bus
);

  localparam int               LCH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] DEF_C    = CNT_W'(DEFAULT_DIV);
  // One extra bit so CHANNELS itself is representable for the range check.
  localparam logic [LCH_W:0]   CH_LIM_C = (LCH_W + 1)'(CHANNELS);

  // Per-channel state
  logic [CNT_W-1:0]    d_r [CHANNELS];   // active ratio
  logic [CNT_W-1:0]    p_r [CHANNELS];   // pending ratio
  logic [CNT_W-1:0]    c_r [CHANNELS];   // position within the period
  logic [CHANNELS-1:0] pend_r;
  logic [CHANNELS-1:0] div_out_r;
  logic [CHANNELS-1:0] tick_r;
  logic                load_ack_r;

  // Next-state values
  logic [CNT_W-1:0]    d_nx_s [CHANNELS];
  logic [CNT_W-1:0]    p_nx_s [CHANNELS];
  logic [CNT_W-1:0]    c_nx_s [CHANNELS];
  logic [CHANNELS-1:0] pend_nx_s;
  logic [CHANNELS-1:0] div_nx_s;
  logic [CHANNELS-1:0] tick_nx_s;
  logic [CHANNELS-1:0] wrap_s;
  logic [CHANNELS-1:0] apply_s;
  logic [CHANNELS-1:0] hit_s;
  logic                load_ok_s;
  logic [CNT_W-1:0]    load_val_s;

  // Load request decode: range check and zero-ratio coercion.
  always_comb begin
    load_ok_s  = bus.load && ({1'b0, bus.load_ch} < CH_LIM_C);
    load_val_s = ONE_C;
    if (bus.load_div == ZERO_C) begin
      load_val_s = ONE_C;
    end else begin
      load_val_s = bus.load_div;
    end
  end

  // Per-channel counting, ratio application and output next values.
  always_comb begin
    wrap_s    = {CHANNELS{1'b0}};
    apply_s   = {CHANNELS{1'b0}};
    hit_s     = {CHANNELS{1'b0}};
    pend_nx_s = pend_r;
    div_nx_s  = {CHANNELS{1'b0}};
    tick_nx_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      d_nx_s[i] = d_r[i];
      p_nx_s[i] = p_r[i];
      c_nx_s[i] = ZERO_C;

      wrap_s[i]  = bus.en[i] && (c_r[i] == (d_r[i] - ONE_C));
      // A pending ratio is swapped in at a period boundary or whenever the
      // channel is idle, so a running channel never sees a truncated period.
      apply_s[i] = pend_r[i] && (wrap_s[i] || !bus.en[i]);
      hit_s[i]   = load_ok_s && (int'(bus.load_ch) == i);

      if (apply_s[i]) begin
        d_nx_s[i] = p_r[i];
      end else begin
        d_nx_s[i] = d_r[i];
      end

      // A load arriving on the application edge wins: P takes the new value
      // and stays pending while D takes the previous P.
      if (hit_s[i]) begin
        p_nx_s[i]    = load_val_s;
        pend_nx_s[i] = 1'b1;
      end else if (apply_s[i]) begin
        p_nx_s[i]    = p_r[i];
        pend_nx_s[i] = 1'b0;
      end else begin
        p_nx_s[i]    = p_r[i];
        pend_nx_s[i] = pend_r[i];
      end

      if (bus.en[i]) begin
        if (wrap_s[i]) begin
          c_nx_s[i] = ZERO_C;
        end else begin
          c_nx_s[i] = c_r[i] + ONE_C;
        end
        tick_nx_s[i] = wrap_s[i];
        // Half-period threshold comes from the ratio in force after this edge,
        // so a freshly applied D=1 is high from its very first cycle.
        div_nx_s[i]  = (c_nx_s[i] >= {1'b0, d_nx_s[i][CNT_W-1:1]});
      end else begin
        c_nx_s[i]    = ZERO_C;
        tick_nx_s[i] = 1'b0;
        div_nx_s[i]  = 1'b0;
      end
    end
  end

  // State and registered outputs; reset clears outputs without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        d_r[i] <= DEF_C;
        p_r[i] <= DEF_C;
        c_r[i] <= ZERO_C;
      end
      pend_r     <= {CHANNELS{1'b0}};
      div_out_r  <= {CHANNELS{1'b0}};
      tick_r     <= {CHANNELS{1'b0}};
      load_ack_r <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        d_r[i] <= d_nx_s[i];
        p_r[i] <= p_nx_s[i];
        c_r[i] <= c_nx_s[i];
      end
      pend_r     <= pend_nx_s;
      div_out_r  <= div_nx_s;
      tick_r     <= tick_nx_s;
      load_ack_r <= load_ok_s;
    end
  end

  assign bus.div_out  = div_out_r;
  assign bus.tick     = tick_r;
  assign bus.load_ack = load_ack_r;

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel, runtime-programmable clock divider and tick generator for the calculator datapath. It derives N independent divided square waves and single-cycle tick strobes from the one system clock. Typical consumers are display-digit multiplexing, keypad debounce sampling and blink timing. Unlike the earlier fixed divider, it adds per-channel enable, a configurable counter width, glitch-free ratio reload at period boundaries, and an asynchronous active-low reset.

## Interface
- `CHANNELS`, 4: number of independent divider channels (1..16).
- `CNT_W`, 32: width of each counter and divide-ratio register.
- `DEFAULT_DIV`, 50: divide ratio loaded into every channel at reset; must be ≥1.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  CHANNELS  per-channel count enable.
- `load`  in  1  single-cycle request to write a new divide ratio.
- `load_ch`  in  $clog2(CHANNELS) (min 1)  target channel of `load`.
- `load_div`  in  CNT_W  new divide ratio; 0 is coerced to 1.
- `load_ack`  out  1  one-cycle pulse confirming an accepted load.
- `div_out`  out  CHANNELS  divided square wave per channel, registered.
- `tick`  out  CHANNELS  one-cycle strobe per period per channel, registered.

## Operation
- Per-channel state:
  - `D`: active ratio, reset `DEFAULT_DIV`.
  - `P`: pending ratio.
  - `pend`: pending flag, reset 0.
  - `c`: counter, reset 0.
  - `H = D >> 1`.
- Counting with `en[i]`=1: `c_next = (c == D-1) ? 0 : c+1`.
  - `tick[i] <= (c == D-1)`.
  - `div_out[i] <= (c_next >= H)`.
  - Period is exactly D cycles. Output is high for D−⌊D/2⌋ cycles and low for ⌊D/2⌋ cycles.
  - Even D gives a 50% duty cycle. D=1 gives `div_out` constant 1 and `tick` high every cycle.
- Disabled (`en[i]`=0): `c` forced to 0; `div_out[i]` and `tick[i]` forced to 0 on the next edge.
- Load acceptance (`load`=1):
  - `load_ch < CHANNELS`: `P[load_ch] <= max(load_div,1)`, `pend <= 1`, and `load_ack` pulses on the next cycle.
  - `load_ch ≥ CHANNELS`: the load is ignored and no ack is issued.
  - A second load to the same channel before application overwrites `P`; the last load wins.
- Ratio application, glitch-free:
  - When `pend`=1 and either the channel wraps (`en`=1, `c == D-1`) or the channel is disabled, then on that edge `D <= P`, `pend <= 0`, `c <= 0`.
  - The tick for the completing period still fires.
  - No partial or runt period is ever produced while enabled.
  - If a load and an application coincide on the same edge, the new load wins: `P` takes the new value, `pend` stays 1, and `D` takes the old `P`.
- Channels are fully independent; simultaneous wraps and ticks on several channels are legal.
- Reset mid-operation:
  - All counters go to 0; all `D` go to `DEFAULT_DIV`.
  - Pending loads are discarded.
  - All outputs go to 0 immediately, without waiting for a clock edge.

## Timing
- Reset values: `div_out`=0, `tick`=0, `load_ack`=0, `c`=0, `pend`=0.
- Startup: after `rst_n` deasserts with `en[i]` held high, count the first active edge as edge 1.
  - `tick[i]` is high after edges D, 2D, 3D, …, each for exactly one cycle.
  - `div_out[i]` rises after edge H and falls after edge D (when H=0, it is high from edge 1).
- Enable rising: same as startup, counted from the first edge that samples `en`=1.
- Enable falling: outputs are 0 one cycle later; the count is lost.
- Load latency:
  - `load_ack` comes 1 cycle after `load`.
  - The new ratio takes effect on the wrap edge of the current period.
  - If the channel is disabled, it takes effect on the first edge with `pend`=1.
  - Worst case is D_old cycles after `load_ack`.
- Arithmetic:
  - Counter compare is unsigned, CNT_W bits.
  - D up to 2^CNT_W−1 is supported.
  - `c` never exceeds D−1, so there is no overflow path.

## Test plan
- Reset defaults: `en`=4'b0001, DEFAULT_DIV=50 -> `tick[0]` high after edges 50, 100, 150; `div_out[0]` high across edges 25..49; channels 1–3 stay 0.
- Mid-period reload: ch1 running D=50; at c=10 apply `load` with ch=1, div=4 -> `load_ack` next cycle; the period completes at 50 cycles with its tick; then period is 4 with 2 high / 2 low.
- Edge ratios: load 0 and load 1 -> both give constant `div_out`=1 and tick every cycle. Load 3 -> 1 low / 2 high, tick every 3 cycles.
- Enable and range handling:
  - `en[2]` dropped at c=17 -> outputs 0 next cycle; re-enabling restarts with the first tick after D edges.
  - A load with `load_ch` out of range (CHANNELS=3, ch=3) -> no ack and no state change.
- Back-to-back loads: ratio 8 then 12 to ch0 before the wrap -> only 12 is applied; the load coinciding with the wrap edge stays pending for the next wrap.
- Async reset mid-count with a load pending -> outputs 0 without a clock; after release D=50 and the pending value is discarded.
